// File: rtl/inv_addroundkey_stage.sv
// inv_addroundkey_stage
//   Registered AddRoundKey stage of the AES inverse-cipher datapath, placed
//   directly upstream of InvMixColumns. A state and its round index are
//   accepted, the matching round key is read from the key-schedule store
//   (fixed one-cycle read latency), and state ^ key is presented together
//   with routing flags for the next stage.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, in_state[127:0], in_round[3:0] : input handshake
//   key_rd_en, key_rd_addr[3:0], key_rd_data[127:0]   : key-store read port
//   out_valid/out_ready, out_state[127:0], out_round[3:0],
//   out_mix, out_last : output handshake and routing flags
//   err_round     : sticky flag, an out-of-range round index was accepted
module inv_addroundkey_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [3:0]   in_round,
  output logic         key_rd_en,
  output logic [3:0]   key_rd_addr,
  input  logic [127:0] key_rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_mix,
  output logic         out_last,
  output logic         err_round
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [127:0] cap_state_q, cap_state_d;
  logic [3:0]   cap_round_q, cap_round_d;
  logic [127:0] out_state_q, out_state_d;
  logic [3:0]   out_round_q, out_round_d;
  logic         out_mix_q, out_mix_d;
  logic         out_last_q, out_last_d;
  logic         out_valid_q, out_valid_d;
  logic         err_round_q, err_round_d;

  logic round_legal;
  logic in_fire;

  // Handshake side. in_ready is forced low during reset so nothing can be
  // accepted (and no key read issued) while the stage is being cleared.
  // In OUT a new input is only taken when the current result drains.
  always_comb begin
    round_legal = (in_round <= NR_L);
    in_ready    = 1'b0;
    if (!rst) begin
      in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    end
    in_fire     = in_valid && in_ready;
    key_rd_en   = in_fire && round_legal;
    key_rd_addr = in_round;
  end

  // Next-state logic. The key store answers one cycle after the read strobe,
  // so key_rd_data is only consumed in KEY, the edge after the capture.
  always_comb begin
    state_d     = state_q;
    cap_state_d = cap_state_q;
    cap_round_d = cap_round_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    out_mix_d   = out_mix_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    err_round_d = err_round_q || (in_fire && !round_legal);

    if (key_rd_en) begin
      cap_state_d = in_state;
      cap_round_d = in_round;
    end

    case (state_q)
      IDLE: begin
        if (key_rd_en) begin
          state_d = KEY;
        end
      end
      KEY: begin
        out_state_d = cap_state_q ^ key_rd_data;
        out_round_d = cap_round_q;
        out_mix_d   = (cap_round_q != 4'd0) && (cap_round_q != NR_L);
        out_last_d  = (cap_round_q == 4'd0);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        // Result drains when out_ready is high; a legal input taken in the
        // same cycle goes straight to KEY for back-to-back operation.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = key_rd_en ? KEY : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_state_q <= '0;
      cap_round_q <= '0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_mix_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_round_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_state_q <= cap_state_d;
      cap_round_q <= cap_round_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_mix_q   <= out_mix_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      err_round_q <= err_round_d;
    end
  end

  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_mix   = out_mix_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign err_round = err_round_q;

endmodule

// File: tb/tb_inv_addroundkey_stage.sv
// tb_inv_addroundkey_stage
//   Directed bench for inv_addroundkey_stage. A small key-store model answers
//   reads one cycle after the strobe and drives random data at all other
//   times. Expected results are queued when a legal state is driven and
//   popped when the stage presents a result.
module tb_inv_addroundkey_stage;

  localparam int NR = 10;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         key_rd_en;
  logic [3:0]   key_rd_addr;
  logic [127:0] key_rd_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_mix;
  logic         out_last;
  logic         err_round;

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         mix;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  inv_addroundkey_stage #(.NR(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_round    (in_round),
    .key_rd_en   (key_rd_en),
    .key_rd_addr (key_rd_addr),
    .key_rd_data (key_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .out_round   (out_round),
    .out_mix     (out_mix),
    .out_last    (out_last),
    .err_round   (err_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-key table of the key-store model.
  function automatic logic [127:0] keyOf(input logic [3:0] r);
    if (r == 4'd5) return 128'h000102030405060708090a0b0c0d0e0f;
    return {16{r, 4'hc}} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Key store: data valid exactly one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (key_rd_en) key_rd_data <= keyOf(key_rd_addr);
    else           key_rd_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one input; the stage is expected to be able to accept it now.
  task automatic applyStimulus(input logic [127:0] s, input logic [3:0] r);
    exp_t e;
    logic legal;
    legal     = (r <= 4'(NR));
    in_valid  = 1'b1;
    in_state  = s;
    in_round  = r;
    #1;
    check("key_rd_en", 128'(key_rd_en), 128'(legal));
    if (legal) begin
      check("key_rd_addr", 128'(key_rd_addr), 128'(r));
      e.st   = s ^ keyOf(r);
      e.rnd  = r;
      e.mix  = (r != 4'd0) && (r != 4'(NR));
      e.last = (r == 4'd0);
      sb.push_back(e);
    end
  endtask

  task automatic checkFields(input string tag, input exp_t e);
    check({tag, "_valid"}, 128'(out_valid), 128'(1));
    check({tag, "_state"}, out_state, e.st);
    check({tag, "_round"}, 128'(out_round), 128'(e.rnd));
    check({tag, "_mix"},   128'(out_mix),   128'(e.mix));
    check({tag, "_last"},  128'(out_last),  128'(e.last));
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 128'(1), 128'(0));
    end else begin
      e = sb.pop_front();
      checkFields(tag, e);
    end
  endtask

  // Full single transaction with out_ready held high.
  task automatic runOne(input string tag, input logic [127:0] s, input logic [3:0] r);
    out_ready = 1'b1;
    applyStimulus(s, r);
    tick();
    in_valid = 1'b0;
    check({tag, "_key_outvalid"}, 128'(out_valid), 128'(0));
    check({tag, "_key_inready"}, 128'(in_ready), 128'(0));
    tick();
    checkOutput(tag);
    tick();
    check({tag, "_drained"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    exp_t front;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_state  = '0;
    in_round  = 4'd3;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_key_rd_en", 128'(key_rd_en), 128'(0));
    tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, 128'(0));
    check("rst_flags", 128'({out_round, out_mix, out_last, err_round}), 128'(0));
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // Basic XOR with the reference vector.
    runOne("basic", 128'h00112233445566778899aabbccddeeff, 4'd5);
    check("basic_literal", out_state, 128'h00102030405060708090a0b0c0d0e0f0);

    // Round flags at the boundaries.
    runOne("r10", {$urandom, $urandom, $urandom, $urandom}, 4'd10);
    runOne("r1",  {$urandom, $urandom, $urandom, $urandom}, 4'd1);
    runOne("r0",  {$urandom, $urandom, $urandom, $urandom}, 4'd0);

    // Backpressure with a second input pending, then back-to-back accept.
    out_ready = 1'b0;
    applyStimulus(128'hdeadbeef_01234567_89abcdef_cafef00d, 4'd3);
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_state = 128'h0123456789abcdeffedcba9876543210;
    in_round = 4'd7;
    front    = sb[0];
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_key_rd_en", 128'(key_rd_en), 128'(0));
      checkFields("bp_hold", front);
      tick();
    end
    out_ready = 1'b1;
    checkOutput("bp_first");
    applyStimulus(128'h0123456789abcdeffedcba9876543210, 4'd7);
    check("b2b_in_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("b2b_gap", 128'(out_valid), 128'(0));
    tick();
    checkOutput("b2b_second");
    tick();

    // Illegal round: no read, no output, sticky error.
    applyStimulus(128'h11111111222222223333333344444444, 4'd11);
    tick();
    in_valid = 1'b0;
    check("ill_err", 128'(err_round), 128'(1));
    check("ill_out_valid", 128'(out_valid), 128'(0));
    check("ill_in_ready", 128'(in_ready), 128'(1));
    tick();
    check("ill_err_sticky", 128'(err_round), 128'(1));
    check("ill_no_output", 128'(out_valid), 128'(0));
    runOne("after_ill", 128'hffeeddccbbaa99887766554433221100, 4'd2);
    check("ill_err_persist", 128'(err_round), 128'(1));

    // Reset while in KEY discards the in-flight state.
    applyStimulus(128'h5a5a5a5aa5a5a5a55a5a5a5aa5a5a5a5, 4'd4);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    sb.delete();
    tick();
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    check("post_rst_err", 128'(err_round), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", 128'(out_valid), 128'(0));
    end
    runOne("post_rst", 128'h000102030405060708090a0b0c0d0e0f, 4'd9);

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
